fixed_absmax_quantizer_int8: RTL and testbench



---
 rtl/fixed_absmax_quantizer_int8_if.sv | 45 ++++
 rtl/fixed_absmax_quantizer_int8.sv | 221 ++++++++++++++++++++++
 tb/tb_fixed_absmax_quantizer_int8.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_absmax_quantizer_int8_if.sv
// Stream bundle for the absmax int8 quantizer: input beat channel and quantized output channel.
// data_out_outlier exists only when QUANT_OUTLIER_FLAG_EN is defined.
interface fixed_absmax_quantizer_int8_if #(
    parameter int IN_WIDTH      = 16,
    parameter int IN_SIZE       = 4,
    parameter int OUT_WIDTH     = 8,
    parameter int MAX_NUM_WIDTH = 16
);
    logic [IN_SIZE*IN_WIDTH-1:0]  data_in;
    logic                         data_in_valid;
    logic                         data_in_ready;
    logic [IN_SIZE*OUT_WIDTH-1:0] data_out;
    logic [MAX_NUM_WIDTH-1:0]     data_out_max_num;
    logic                         data_out_valid;
    logic                         data_out_ready;
`ifdef QUANT_OUTLIER_FLAG_EN
    logic                         data_out_outlier;
`endif

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready,
        output data_out,
        output data_out_max_num,
        output data_out_valid,
`ifdef QUANT_OUTLIER_FLAG_EN
        output data_out_outlier,
`endif
        input  data_out_ready
    );

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready,
        input  data_out,
        input  data_out_max_num,
        input  data_out_valid,
`ifdef QUANT_OUTLIER_FLAG_EN
        input  data_out_outlier,
`endif
        output data_out_ready
    );
endinterface

// File: rtl/fixed_absmax_quantizer_int8.sv
// Vector-wise absmax int8 quantizer: buffer a vector, divide QMAX by its absmax, stream int8 beats.
// Optional QUANT_OUTLIER_FLAG_EN adds a registered absmax >= OUTLIER_THRESHOLD flag per vector.
module fixed_absmax_quantizer_int8 #(
    parameter int IN_WIDTH          = 16,
    parameter int IN_FRAC_WIDTH     = 8,
    parameter int IN_SIZE           = 4,
    parameter int IN_DEPTH          = 3,
    parameter int OUT_WIDTH         = 8,
    parameter int RECIP_FRAC_WIDTH  = 16,
    parameter int MAX_NUM_WIDTH     = 16,
    parameter int OUTLIER_THRESHOLD = 2 ** (IN_WIDTH - 2)
) (
    input logic                          clk,
    input logic                          rst,
    fixed_absmax_quantizer_int8_if.slave bus
);
    localparam int QMAX       = 2 ** (OUT_WIDTH - 1) - 1;
    localparam int QW         = OUT_WIDTH - 1 + RECIP_FRAC_WIDTH;
    localparam int DIV_CYCLES = QW;
    localparam int BCW        = $clog2(IN_DEPTH + 1);
    localparam int DCW        = $clog2(DIV_CYCLES);
    localparam int PW         = IN_WIDTH + QW + 1;

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    localparam logic [QW-1:0]                DIVIDEND = QW'(QMAX) << RECIP_FRAC_WIDTH;
    localparam logic signed [PW-1:0]         QMAX_P   = PW'(QMAX);
    localparam logic signed [PW-1:0]         QMIN_P   = -QMAX_P;
    localparam logic signed [OUT_WIDTH-1:0]  QMAX_O   = OUT_WIDTH'(QMAX);
    localparam logic signed [OUT_WIDTH-1:0]  QMIN_O   = -QMAX_O;

    // The ratio x/absmax is independent of the binary point, so IN_FRAC_WIDTH only bounds-checks.
    if (MAX_NUM_WIDTH < IN_WIDTH || IN_FRAC_WIDTH > IN_WIDTH ||
        OUTLIER_THRESHOLD > 2 ** IN_WIDTH) begin : g_bad_cfg
        $error("fixed_absmax_quantizer_int8: inconsistent parameters");
    end

    function automatic logic [IN_WIDTH-1:0] abs_val(input logic signed [IN_WIDTH-1:0] x);
        logic signed [IN_WIDTH-1:0] neg;
        neg = -x;
        return x[IN_WIDTH-1] ? $unsigned(neg) : $unsigned(x);
    endfunction

    function automatic logic signed [PW-1:0] round_half_up(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] half;
        half = '0;
        half[RECIP_FRAC_WIDTH-1] = 1'b1;
        return (p + half) >>> RECIP_FRAC_WIDTH;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
        if (v > QMAX_P)      return QMAX_O;
        else if (v < QMIN_P) return QMIN_O;
        else                 return v[OUT_WIDTH-1:0];
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] quant_lane(input logic signed [IN_WIDTH-1:0] x,
                                                               input logic [QW-1:0] r);
        logic signed [PW-1:0] prod;
        prod = PW'(x) * PW'($signed({1'b0, r}));
        return saturate(round_half_up(prod));
    endfunction

    logic [1:0]                   state_q, state_d;
    logic [BCW-1:0]               beat_cnt_q, beat_cnt_d;
    logic [BCW-1:0]               emit_cnt_q, emit_cnt_d;
    logic [DCW-1:0]               div_cnt_q, div_cnt_d;
    logic [IN_WIDTH-1:0]          absmax_q, absmax_d;
    logic [IN_WIDTH-1:0]          rem_q, rem_d;
    logic [QW-1:0]                quo_q, quo_d;
    logic [IN_SIZE*OUT_WIDTH-1:0] data_q, data_d;
    logic [MAX_NUM_WIDTH-1:0]     max_q, max_d;
    logic                         vld_q, vld_d;
    logic [IN_SIZE*IN_WIDTH-1:0]  buf_q [IN_DEPTH];

    logic [IN_WIDTH-1:0]          beat_max;
    logic [IN_WIDTH-1:0]          absmax_nxt;
    logic [IN_WIDTH:0]            rem_shift;
    logic                         rem_ge;
    logic                         in_fire;

`ifdef QUANT_OUTLIER_FLAG_EN
    localparam logic [IN_WIDTH:0] OUTLIER_THR = (IN_WIDTH + 1)'(OUTLIER_THRESHOLD);
    logic                         outlier_q, outlier_d;
`endif

    assign in_fire = (state_q == S_FILL) && bus.data_in_valid;

    // Running absmax including the beat currently offered.
    always_comb begin
        beat_max = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (abs_val(bus.data_in[i*IN_WIDTH +: IN_WIDTH]) > beat_max)
                beat_max = abs_val(bus.data_in[i*IN_WIDTH +: IN_WIDTH]);
        end
        absmax_nxt = (beat_max > absmax_q) ? beat_max : absmax_q;
    end

    // One restoring-division step: remainder stays below absmax, so IN_WIDTH bits suffice.
    always_comb begin
        rem_shift = {rem_q, quo_q[QW-1]};
        rem_ge    = (rem_shift >= {1'b0, absmax_q});
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        emit_cnt_d = emit_cnt_q;
        div_cnt_d  = div_cnt_q;
        absmax_d   = absmax_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        data_d     = data_q;
        max_d      = max_q;
        vld_d      = vld_q;
`ifdef QUANT_OUTLIER_FLAG_EN
        outlier_d  = outlier_q;
`endif
        case (state_q)
            S_FILL: begin
                if (in_fire) begin
                    absmax_d = absmax_nxt;
                    if (beat_cnt_q == BCW'(IN_DEPTH - 1)) begin
                        beat_cnt_d = '0;
                        div_cnt_d  = '0;
                        rem_d      = '0;
`ifdef QUANT_OUTLIER_FLAG_EN
                        outlier_d  = ({1'b0, absmax_nxt} >= OUTLIER_THR);
`endif
                        if (absmax_nxt == '0) begin
                            quo_d   = '0;
                            state_d = S_EMIT;
                        end else begin
                            quo_d   = DIVIDEND;
                            state_d = S_DIV;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            S_DIV: begin
                rem_d     = rem_ge ? IN_WIDTH'(rem_shift - {1'b0, absmax_q}) : rem_shift[IN_WIDTH-1:0];
                quo_d     = {quo_q[QW-2:0], rem_ge};
                div_cnt_d = div_cnt_q + DCW'(1);
                if (div_cnt_q == DCW'(DIV_CYCLES - 1)) begin
                    div_cnt_d = '0;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                // Output register refills when empty or when the held beat is taken.
                if (!vld_q || bus.data_out_ready) begin
                    if (emit_cnt_q != BCW'(IN_DEPTH)) begin
                        for (int i = 0; i < IN_SIZE; i++)
                            data_d[i*OUT_WIDTH +: OUT_WIDTH] =
                                quant_lane(buf_q[emit_cnt_q][i*IN_WIDTH +: IN_WIDTH], quo_q);
                        max_d      = MAX_NUM_WIDTH'(absmax_q);
                        vld_d      = 1'b1;
                        emit_cnt_d = emit_cnt_q + BCW'(1);
                    end else begin
                        vld_d      = 1'b0;
                        emit_cnt_d = '0;
                        absmax_d   = '0;
`ifdef QUANT_OUTLIER_FLAG_EN
                        outlier_d  = 1'b0;
`endif
                        state_d    = S_FILL;
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FILL;
            beat_cnt_q <= '0;
            emit_cnt_q <= '0;
            div_cnt_q  <= '0;
            absmax_q   <= '0;
            data_q     <= '0;
            max_q      <= '0;
            vld_q      <= 1'b0;
`ifdef QUANT_OUTLIER_FLAG_EN
            outlier_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            emit_cnt_q <= emit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            absmax_q   <= absmax_d;
            data_q     <= data_d;
            max_q      <= max_d;
            vld_q      <= vld_d;
`ifdef QUANT_OUTLIER_FLAG_EN
            outlier_q  <= outlier_d;
`endif
        end
    end

    // Vector buffer and divider datapath carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (in_fire)
            buf_q[beat_cnt_q] <= bus.data_in;
        rem_q <= rem_d;
        quo_q <= quo_d;
    end

    assign bus.data_in_ready    = (state_q == S_FILL);
    assign bus.data_out         = data_q;
    assign bus.data_out_max_num = max_q;
    assign bus.data_out_valid   = vld_q;
`ifdef QUANT_OUTLIER_FLAG_EN
    assign bus.data_out_outlier = vld_q & outlier_q;
`endif
endmodule

// File: tb/tb_fixed_absmax_quantizer_int8.sv
// Randomized self-checking bench for fixed_absmax_quantizer_int8 against an arithmetic reference model.
module tb_fixed_absmax_quantizer_int8;
    localparam int IN_WIDTH         = 16;
    localparam int IN_SIZE          = 4;
    localparam int IN_DEPTH         = 3;
    localparam int OUT_WIDTH        = 8;
    localparam int RECIP_FRAC_WIDTH = 16;
    localparam int MAX_NUM_WIDTH    = 16;
    localparam int QMAX             = 127;
    localparam int DIV_CYCLES       = OUT_WIDTH - 1 + RECIP_FRAC_WIDTH;
    localparam int THRESH           = 1 << (IN_WIDTH - 2);

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   t_acc;
    int   vec   [IN_DEPTH][IN_SIZE];
    int   exp_q [IN_DEPTH][IN_SIZE];
    int   exp_max;
    int   exp_out;
    longint exp_recip;

    fixed_absmax_quantizer_int8_if bus_if ();

    fixed_absmax_quantizer_int8 dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference: q = floor((x*recip + 2^(F-1)) / 2^F), clipped to +-QMAX.
    function automatic int ref_quant(input int x, input longint recip);
        longint scale;
        longint v;
        longint q;
        scale = longint'(1) << RECIP_FRAC_WIDTH;
        v = longint'(x) * recip + scale / 2;
        if (v >= 0) q = v / scale;
        else        q = -((-v + scale - 1) / scale);
        if (q > QMAX)  q = QMAX;
        if (q < -QMAX) q = -QMAX;
        return int'(q);
    endfunction

    task automatic build_expected();
        int a;
        exp_max = 0;
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++) begin
                a = (vec[b][i] < 0) ? -vec[b][i] : vec[b][i];
                if (a > exp_max) exp_max = a;
            end
        exp_recip = (exp_max == 0) ? 0 : (longint'(QMAX) << RECIP_FRAC_WIDTH) / exp_max;
        exp_out   = (exp_max >= THRESH) ? 1 : 0;
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++)
                exp_q[b][i] = ref_quant(vec[b][i], exp_recip);
    endtask

    task automatic send_vector();
        int wait_c;
        bit rdy;
        for (int b = 0; b < IN_DEPTH; b++) begin
            for (int i = 0; i < IN_SIZE; i++)
                bus_if.data_in[i*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(vec[b][i]);
            bus_if.data_in_valid = 1'b1;
            wait_c = 0;
            forever begin
                rdy = bus_if.data_in_ready;
                @(posedge clk); #1;
                if (rdy) break;
                wait_c++;
                if (wait_c > 100) begin
                    check_val("in_ready_timeout", 0, 1);
                    break;
                end
            end
        end
        bus_if.data_in_valid = 1'b0;
        t_acc = cyc;
    endtask

    task automatic recv_vector(input int stall_beat, input int stall_len, input bit rand_bp);
        int beat;
        int first;
        int guard;
        int stall_left;
        int exp_lat;
        bit v;
        bit rdy;
        logic signed [OUT_WIDTH-1:0] lane;
        beat = 0;
        first = -1;
        guard = 0;
        stall_left = stall_len;
        exp_lat = (exp_max == 0) ? 1 : DIV_CYCLES + 1;
        while (beat < IN_DEPTH) begin
            v = bus_if.data_out_valid;
            if (v && first < 0) begin
                first = cyc;
                check_val("latency", first - t_acc, exp_lat);
            end
            if (v && beat == stall_beat && stall_left > 0) rdy = 1'b0;
            else if (rand_bp)                             rdy = ($urandom_range(0, 3) != 0);
            else                                          rdy = 1'b1;
            bus_if.data_out_ready = rdy;
            check_val("in_ready_busy", bus_if.data_in_ready, 0);
            if (v) begin
                for (int i = 0; i < IN_SIZE; i++) begin
                    lane = bus_if.data_out[i*OUT_WIDTH +: OUT_WIDTH];
                    check_val($sformatf("beat%0d_lane%0d", beat, i), int'(lane), exp_q[beat][i]);
                end
                check_val("max_num", bus_if.data_out_max_num, exp_max);
`ifdef QUANT_OUTLIER_FLAG_EN
                check_val("outlier", bus_if.data_out_outlier, exp_out);
`endif
                if (rdy) beat++;
                else     stall_left--;
            end
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                check_val("out_timeout", beat, IN_DEPTH);
                break;
            end
        end
        bus_if.data_out_ready = 1'b0;
        check_val("valid_after_vec", bus_if.data_out_valid, 0);
        check_val("ready_after_vec", bus_if.data_in_ready, 1);
    endtask

    task automatic run_vector(input int stall_beat, input int stall_len, input bit rand_bp);
        build_expected();
        send_vector();
        recv_vector(stall_beat, stall_len, rand_bp);
    endtask

    task automatic load_identity();
        vec[0][0] = 127;  vec[0][1] = -127; vec[0][2] = 0;    vec[0][3] = 5;
        vec[1][0] = -1;   vec[1][1] = 64;   vec[1][2] = -64;  vec[1][3] = 100;
        vec[2][0] = 1;    vec[2][1] = -5;   vec[2][2] = 126;  vec[2][3] = -126;
    endtask

    task automatic load_random();
        int k;
        int lim;
        k = $urandom_range(0, 15);
        lim = (1 << k) - 1;
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++)
                vec[b][i] = int'($urandom_range(0, 2 * lim)) - lim;
        if ($urandom_range(0, 5) == 0)
            vec[$urandom_range(0, IN_DEPTH - 1)][$urandom_range(0, IN_SIZE - 1)] = -32768;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus_if.data_in = '0;
        bus_if.data_in_valid = 1'b0;
        bus_if.data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", bus_if.data_out_valid, 0);
        check_val("rst_data", bus_if.data_out, 0);
        check_val("rst_max", bus_if.data_out_max_num, 0);
`ifdef QUANT_OUTLIER_FLAG_EN
        check_val("rst_outlier", bus_if.data_out_outlier, 0);
`endif
        rst_n = 1'b1;
        #1;
        check_val("rst_ready", bus_if.data_in_ready, 1);

        // identity, absmax 127
        load_identity();
        run_vector(-1, 0, 1'b0);

        // most-negative input in one lane
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++)
                vec[b][i] = (b * IN_SIZE + i) * 37 - 200;
        vec[1][2] = -32768;
        run_vector(-1, 0, 1'b0);

        // all zeros, divider skipped
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++)
                vec[b][i] = 0;
        run_vector(-1, 0, 1'b0);

        // backpressure on beat 1 for 5 cycles
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++)
                vec[b][i] = (b + 1) * 1000 - i * 777;
        run_vector(1, 5, 1'b0);

        // reset in the middle of the divide, then a fresh identity vector
        load_identity();
        build_expected();
        send_vector();
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("middiv_rst_valid", bus_if.data_out_valid, 0);
        check_val("middiv_rst_data", bus_if.data_out, 0);
        check_val("middiv_rst_max", bus_if.data_out_max_num, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_val("middiv_ready", bus_if.data_in_ready, 1);
        run_vector(-1, 0, 1'b0);

        // outlier threshold sides
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++)
                vec[b][i] = i * 500 - b * 300;
        vec[2][1] = 20000;
        run_vector(-1, 0, 1'b0);
        for (int b = 0; b < IN_DEPTH; b++)
            for (int i = 0; i < IN_SIZE; i++)
                vec[b][i] = i * 25 - b * 10;
        vec[0][3] = -100;
        run_vector(-1, 0, 1'b0);
        vec[0][0] = THRESH;
        run_vector(-1, 0, 1'b0);

        // randomized vectors with random downstream backpressure
        for (int n = 0; n < 20; n++) begin
            load_random();
            run_vector(-1, 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
